// File: rtl/march_bist.sv
// march_bist: March C- memory BIST engine over a single-port synchronous RAM,
// running up to four data backgrounds with first-fail logging and stop-on-fail.
module march_bist #(
  parameter int DTA_SIZE = 8,
  parameter int ADR_SIZE = 4,
  parameter int NUM_BG   = 2,
  parameter int FCNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop_on_fail,
  input  logic [DTA_SIZE-1:0] mem_rdata,
  output logic [ADR_SIZE-1:0] mem_addr,
  output logic [DTA_SIZE-1:0] mem_wdata,
  output logic                mem_we,
  output logic                mem_re,
  output logic                busy,
  output logic                done,
  output logic                status,
  output logic [ADR_SIZE-1:0] fail_addr,
  output logic [2:0]          fail_elem,
  output logic [1:0]          fail_bg,
  output logic [FCNT_W-1:0]   fail_cnt
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;
  localparam logic [1:0] BG_LAST = 2'(NUM_BG - 1);
  state_t r_state, w_state_nxt;
  logic [ADR_SIZE-1:0] r_cnt, r_cmp_addr, w_addr;
  logic [2:0] r_elem, r_cmp_elem;
  logic [1:0] r_bg, r_cmp_bg;
  logic r_op, r_sof, r_cmp_v;
  logic [DTA_SIZE-1:0] r_cmp_exp, w_pat;
  logic w_rd, w_wpol, w_rpol, w_last_op, w_end, w_mis, w_abort, w_issue, w_start;

  // bg0 is all zeros; bg k>0 repeats 2^(k-1) ones then 2^(k-1) zeros from bit0
  function automatic logic [DTA_SIZE-1:0] bg_pat(input logic [1:0] k);
    int kk;
    bg_pat = '0;
    kk = int'(k);
    for (int i = 0; i < DTA_SIZE; i++)
      bg_pat[i] = (kk != 0) && (((i >> (kk - 1)) & 1) == 0);
  endfunction

  always_comb begin
    w_pat       = bg_pat(r_bg);
    w_rd        = (r_elem != 3'd0) && !r_op;
    w_wpol      = (r_elem == 3'd1) || (r_elem == 3'd3);
    w_rpol      = (r_elem == 3'd2) || (r_elem == 3'd4);
    w_last_op   = (r_elem == 3'd0) || (r_elem == 3'd5) || r_op;
    w_end       = w_last_op && (&r_cnt) && (r_elem == 3'd5) && (r_bg == BG_LAST);
    w_addr      = (r_elem >= 3'd3) ? ~r_cnt : r_cnt;
    w_mis       = r_cmp_v && (mem_rdata != r_cmp_exp);
    w_abort     = r_sof && w_mis;
    w_issue     = (r_state == S_RUN) && !w_abort;
    w_start     = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    w_state_nxt = w_start                           ? S_RUN   :
                  (r_state == S_RUN && w_abort)     ? S_DONE  :
                  (w_issue && w_end)                ? S_FLUSH :
                  (r_state == S_FLUSH)              ? S_DONE  : r_state;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;

  // Counters only advance on an issued op, so address/data hold once the run ends
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_cnt  <= '0;
      r_elem <= '0;
      r_bg   <= '0;
      r_op   <= 1'b0;
      r_sof  <= 1'b0;
    end else if (w_start) begin
      r_cnt  <= '0;
      r_elem <= '0;
      r_bg   <= '0;
      r_op   <= 1'b0;
      r_sof  <= stop_on_fail;
    end else if (w_issue && !w_end) begin
      r_op <= !w_last_op;
      if (w_last_op) begin
        r_cnt <= r_cnt + 1'b1;
        if (&r_cnt) begin
          r_elem <= (r_elem == 3'd5) ? 3'd0 : r_elem + 3'd1;
          if (r_elem == 3'd5) r_bg <= r_bg + 2'd1;
        end
      end
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_cmp_v    <= 1'b0;
      r_cmp_exp  <= '0;
      r_cmp_addr <= '0;
      r_cmp_elem <= '0;
      r_cmp_bg   <= '0;
    end else begin
      r_cmp_v    <= w_issue && w_rd;
      r_cmp_exp  <= w_pat ^ {DTA_SIZE{w_rpol}};
      r_cmp_addr <= w_addr;
      r_cmp_elem <= r_elem;
      r_cmp_bg   <= r_bg;
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      fail_cnt  <= '0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_bg   <= '0;
    end else if (w_start) begin
      fail_cnt  <= '0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_bg   <= '0;
    end else if (w_mis) begin
      if (!(&fail_cnt)) fail_cnt <= fail_cnt + 1'b1;
      if (fail_cnt == '0) begin
        fail_addr <= r_cmp_addr;
        fail_elem <= r_cmp_elem;
        fail_bg   <= r_cmp_bg;
      end
    end

  assign mem_addr  = w_addr;
  assign mem_wdata = w_pat ^ {DTA_SIZE{w_wpol}};
  assign mem_we    = w_issue && !w_rd;
  assign mem_re    = w_issue && w_rd;
  assign busy      = (r_state == S_RUN) || (r_state == S_FLUSH);
  assign done      = r_state == S_DONE;
  assign status    = done && (fail_cnt == '0);
endmodule

// File: tb/tb_march_bist.sv
// tb_march_bist: scoreboard bench for march_bist against a behavioural RAM with
// an injectable bit0 stuck-at-1 fault at address 5.
module tb_march_bist;
  typedef struct packed {logic [3:0] addr; logic we; logic [7:0] data;} op_t;
  logic clk, rst, start, stop_on_fail, fault_en;
  logic [7:0] mem_rdata, mem_wdata, rdata2, wdata2;
  logic [3:0] mem_addr, fail_addr, addr2, fail_addr2;
  logic mem_we, mem_re, busy, done, status, we2, re2, busy2, done2, status2;
  logic [2:0] fail_elem, fail_elem2;
  logic [1:0] fail_bg, fail_bg2, fail_cnt2;
  logic [7:0] fail_cnt;
  logic [7:0] mem [16];
  logic [7:0] mem2 [16];
  op_t q[$];
  op_t mon_e;
  op_t log_ops [2048];
  int ops_seen, n_chk, n_fail;

  march_bist u_dut (
    .clk(clk), .rst(rst), .start(start), .stop_on_fail(stop_on_fail),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .busy(busy), .done(done), .status(status),
    .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_bg(fail_bg), .fail_cnt(fail_cnt)
  );

  march_bist #(.FCNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .stop_on_fail(stop_on_fail),
    .mem_rdata(rdata2), .mem_addr(addr2), .mem_wdata(wdata2),
    .mem_we(we2), .mem_re(re2), .busy(busy2), .done(done2), .status(status2),
    .fail_addr(fail_addr2), .fail_elem(fail_elem2), .fail_bg(fail_bg2), .fail_cnt(fail_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= (fault_en && mem_addr == 4'd5) ? (mem[mem_addr] | 8'h01) : mem[mem_addr];
    if (we2) mem2[addr2] <= wdata2;
    if (re2) rdata2 <= (addr2 == 4'd5) ? (mem2[addr2] | 8'h01) : mem2[addr2];
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (mem_we || mem_re) begin
      if (q.size() == 0) chk("extra_op", 1, 0);
      else begin
        mon_e = q.pop_front();
        chk("op_addr", mem_addr, mon_e.addr);
        chk("op_we", mem_we, mon_e.we);
        chk("op_re", mem_re, !mon_e.we);
        if (mon_e.we) chk("op_wdata", mem_wdata, mon_e.data);
      end
      log_ops[ops_seen % 2048] = '{mem_addr, mem_we, mem_wdata};
      ops_seen++;
    end

  task automatic build();
    logic [7:0] pat [4] = '{8'h00, 8'h55, 8'h33, 8'h0F};
    logic [3:0] a;
    logic [7:0] p;
    q.delete();
    for (int bg = 0; bg < 2; bg++)
      for (int el = 0; el < 6; el++)
        for (int i = 0; i < 16; i++) begin
          a = (el < 3) ? 4'(i) : 4'(15 - i);
          p = pat[bg];
          case (el)
            0: q.push_back('{a, 1'b1, p});
            1, 3: begin q.push_back('{a, 1'b0, p}); q.push_back('{a, 1'b1, ~p}); end
            2, 4: begin q.push_back('{a, 1'b0, ~p}); q.push_back('{a, 1'b1, p}); end
            default: q.push_back('{a, 1'b0, p});
          endcase
        end
  endtask

  task automatic pulse_start(input logic sof);
    build();
    @(posedge clk); #1;
    stop_on_fail = sof;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stop_on_fail = 1'b0;
  endtask

  task automatic run(input logic sof, input int ex1, input int ex2, output int n);
    pulse_start(sof);
    n = 1;
    chk("busy_t0", busy, 1);
    chk("done_clr", done, 0);
    while (!done && n < 2000) begin
      @(posedge clk); #1;
      n++;
      start = (n == ex1) || (n == ex2);
    end
    start = 1'b0;
    if (!done) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int n, b;
    rst = 1'b0; start = 1'b0; stop_on_fail = 1'b0; fault_en = 1'b0;
    for (int i = 0; i < 16; i++) begin mem[i] = 8'h00; mem2[i] = 8'h00; end
    repeat (3) @(posedge clk); #1;
    chk("rst_outs", {mem_addr, mem_wdata, mem_we, mem_re, busy, done, status,
                     fail_addr, fail_elem, fail_bg, fail_cnt}, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("idle_strobes", {mem_we, mem_re, busy, done}, 0);

    b = ops_seen;
    run(1'b0, -1, -1, n);
    chk("pass_done_cyc", n, 322);
    chk("pass_status", status, 1);
    chk("pass_fcnt", fail_cnt, 0);
    chk("pass_busy", busy, 0);
    chk("pass_ops", ops_seen - b, 320);
    chk("pass_q_empty", q.size(), 0);
    chk("m3_first", {log_ops[b+80].addr, log_ops[b+80].we}, {4'd15, 1'b0});
    chk("m3_w1", {log_ops[b+81].addr, log_ops[b+81].we, log_ops[b+81].data}, {4'd15, 1'b1, 8'hFF});
    chk("m3_last", log_ops[b+111].addr, 0);
    chk("bg1_m0", {log_ops[b+160].we, log_ops[b+160].data}, {1'b1, 8'h55});
    chk("bg1_w1", {log_ops[b+177].we, log_ops[b+177].data}, {1'b1, 8'hAA});

    fault_en = 1'b1;
    b = ops_seen;
    run(1'b0, -1, -1, n);
    chk("flt_done_cyc", n, 322);
    chk("flt_status", status, 0);
    chk("flt_addr", fail_addr, 5);
    chk("flt_elem", fail_elem, 1);
    chk("flt_bg", fail_bg, 0);
    chk("flt_cnt", fail_cnt, 5);
    chk("flt_ops", ops_seen - b, 320);
    chk("sat_cnt", fail_cnt2, 3);
    chk("sat_status", {done2, status2}, 2'b10);

    b = ops_seen;
    run(1'b1, -1, -1, n);
    chk("sof_done_cyc", n, 29);
    chk("sof_ops", ops_seen - b, 27);
    chk("sof_cnt", fail_cnt, 1);
    chk("sof_status", status, 0);
    chk("sof_addr", {fail_addr, fail_elem, fail_bg}, {4'd5, 3'd1, 2'd0});
    q.delete();
    repeat (6) @(posedge clk); #1;
    chk("sof_quiet", ops_seen - b, 27);
    chk("sof_done_hold", {done, status}, 2'b10);
    fault_en = 1'b0;

    pulse_start(1'b0);
    repeat (59) @(posedge clk); #1;
    chk("mid_m2_strobe", mem_we | mem_re, 1);
    rst = 1'b0;
    #1;
    chk("rst_async_outs", {mem_addr, mem_wdata, mem_we, mem_re, busy, done, status,
                           fail_addr, fail_elem, fail_bg, fail_cnt}, 0);
    q.delete();
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;
    b = ops_seen;
    repeat (10) @(posedge clk); #1;
    chk("post_rst_quiet", {ops_seen - b, 32'(busy), 32'(done)}, 0);
    run(1'b0, -1, -1, n);
    chk("rerun_done_cyc", n, 322);
    chk("rerun_status", {status, fail_cnt}, {1'b1, 8'h00});

    b = ops_seen;
    run(1'b0, 100, 321, n);
    chk("ign_done_cyc", n, 322);
    chk("ign_status", {status, fail_cnt}, {1'b1, 8'h00});
    chk("ign_ops", ops_seen - b, 320);
    chk("ign_q_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/march_bist.md
Name: march_bist

Overview:
- Parametrised memory BIST engine; next generation of the current BIST top.
- Runs March C- over an external single-port synchronous RAM, DEPTH = 2^ADR_SIZE words, across up to four data backgrounds.
- Adds fail logging (first failing address, element and background, plus a saturating fail count) and an optional stop-on-first-fail mode.
- Sits between the system controller (start/done/status) and the RAM under test.

Parameters:
- DTA_SIZE, 8, memory word width (>=2).
- ADR_SIZE, 4, address width; DEPTH = 2^ADR_SIZE.
- NUM_BG, 2, number of data backgrounds run (1..4).
- FCNT_W, 8, width of fail counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE or DONE.
- stop_on_fail  in  1  sampled with start. 1 = end the test at the first mismatch.
- mem_rdata  in  DTA_SIZE  RAM read data, valid the cycle after mem_re.
- mem_addr  out  ADR_SIZE  RAM address.
- mem_wdata  out  DTA_SIZE  RAM write data.
- mem_we  out  1  RAM write strobe.
- mem_re  out  1  RAM read strobe.
- busy  out  1  high from the first op cycle until done.
- done  out  1  level, held until the next start or reset.
- status  out  1  1 = pass; valid while done=1.
- fail_addr  out  ADR_SIZE  address of the first mismatch.
- fail_elem  out  3  March element (0..5) of the first mismatch.
- fail_bg  out  2  background index of the first mismatch.
- fail_cnt  out  FCNT_W  mismatch count; saturates at all-ones.

Behaviour:
- Reset (rst=0, async): FSM to IDLE. All outputs 0, including mem_we, mem_re, mem_addr, mem_wdata, done, status, busy and all fail_* outputs.
- FSM states: IDLE -> RUN -> FLUSH -> DONE. DONE -> RUN on start.
- start in IDLE/DONE:
  - Clears done, status and fail_*; latches stop_on_fail.
  - First op is issued the next cycle (T0).
  - start while in RUN or FLUSH is ignored.
- Backgrounds: bg k "0" pattern = repeating 2^k-bit block of 0s then 1s across the word; "1" pattern = bitwise inverse.
  - bg0 = 0x00, bg1 = 0x55 (bit0 = 1), bg2 = 0x33, bg3 = 0x0F for width 8.
- March C- per background, one op per cycle, no idle cycles between ops, elements or backgrounds:
  - M0 up: w0.
  - M1 up: r0, w1.
  - M2 up: r1, w0.
  - M3 down: r0, w1.
  - M4 down: r1, w0.
  - M5 down: r0.
  - "up" = address 0..DEPTH-1; "down" = DEPTH-1..0.
  - Multi-op elements perform all their ops on one address before advancing.
  - Per background: 10·DEPTH ops. Total K = 10·DEPTH·NUM_BG ops in cycles T0..T0+K-1.
- Read pipeline:
  - Read issued in cycle t: mem_re=1, mem_we=0.
  - mem_rdata is compared in cycle t+1 against the expected value, address, element and bg delayed by one stage.
  - The compare and a new op in the same cycle are independent.
- Mismatch:
  - fail_cnt increments, saturating at all-ones.
  - On the first mismatch only, capture fail_addr, fail_elem and fail_bg.
- FLUSH: entered after op T0+K-1 issues; mem_we = mem_re = 0; performs the final compare.
  - done = 1 and busy = 0 from cycle T0+K+1.
  - status = 1 iff fail_cnt == 0.
- stop_on_fail = 1:
  - On the first mismatch compare cycle, suppress the op issued in that cycle; mem_we and mem_re are 0 that cycle.
  - done = 1, status = 0 the next cycle; fail_cnt = 1.
- Outside RUN, mem_we = mem_re = 0; mem_addr and mem_wdata hold their last values.
- A start arriving in the same cycle done would rise: done rises first, start is not seen.
- Reset during RUN aborts immediately: no further RAM strobes, and the engine requires a new start.

Test Plan:
- Fault-free RAM model, defaults (DEPTH 16, NUM_BG 2), start at cycle 0 -> 320 ops in cycles 1..320; done = 1, status = 1 at cycle 322; fail_cnt = 0; busy low from 322.
- Bit0 stuck-at-1 at address 5, stop_on_fail = 0 -> status = 0; fail_addr = 5, fail_elem = 1, fail_bg = 0; fail_cnt = 5 (bg0 M1/M3/M5, bg1 M2/M4).
- Same fault, stop_on_fail = 1 -> done the cycle after the M1 read of address 5 is compared; no RAM strobe after that compare; fail_cnt = 1; status = 0.
- Ordering check, fault-free -> in bg0, M3's first op (r0) addresses 15 with mem_re=1 and its next (w1) addresses 15 with mem_wdata = 0xFF; M3 ends at address 0. bg1 M0 writes 0x55; bg1 "1" writes = 0xAA.
- rst pulled low mid-M2 -> same cycle all outputs 0 and strobes stay 0 after release; start pulse then reruns to a pass identical to the first scenario.
- start pulsed while busy, and start during FLUSH -> ignored; timing and results identical to the first scenario. fail_cnt with FCNT_W = 2 and 5 fails -> saturates at 3.
